// File: rtl/mul_pkg.sv
// ============================================================
// mul_pkg: shared state encodings for the shift-add multiplier
// Rev 1.0
// ============================================================
`default_nettype none

package mul_pkg;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;
endpackage

`default_nettype wire

// File: rtl/mul_seq_datapath.sv
// ============================================================
// mul_seq_datapath: magnitude capture, shift-add accumulate, product register
// Rev 1.0
// ============================================================
`default_nettype none

module mul_seq_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               b_zero_o,
  output logic               mplr_zero_next_o,
  output logic [2*WIDTH-1:0] product_o
);
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   a_mag, b_mag, mplr_shift;
  logic [2*WIDTH-1:0] acc_next, prod_res;

  // Unsigned reinterpretation of the negation keeps the most negative value exact.
  assign a_mag = (SIGNED && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (SIGNED && b_i[WIDTH-1]) ? -b_i : b_i;

  assign b_zero_o         = (b_mag == '0);
  assign acc_next         = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mplr_shift       = mplr_q >> 1;
  assign mplr_zero_next_o = (mplr_shift == '0);
  assign prod_res         = neg_q ? -acc_next : acc_next;
  assign product_o        = product_q;

  always_comb begin
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load_i) begin
      mcand_d = {{WIDTH{1'b0}}, a_mag};
      mplr_d  = b_mag;
      acc_d   = '0;
      neg_d   = SIGNED && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      if (b_mag == '0) begin
        product_d = '0;
      end
    end else if (step_i) begin
      acc_d   = acc_next;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_shift;
      if (mplr_zero_next_o) begin
        product_d = prod_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mul_seq_shift_add.sv
// ============================================================
// mul_seq_shift_add: start/done sequential shift-add multiplier (controller + datapath)
// Rev 1.0
// ============================================================
`default_nettype none

module mul_seq_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  state_e state_q, state_d;
  logic   load, step, b_zero, mplr_zero_next;

  mul_seq_datapath #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_datapath (
    .clk              (clk),
    .rst              (rst),
    .load_i           (load),
    .step_i           (step),
    .a_i              (a_i),
    .b_i              (b_i),
    .b_zero_o         (b_zero),
    .mplr_zero_next_o (mplr_zero_next),
    .product_o        (product_o)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (mplr_zero_next) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_mul_seq_shift_add.sv
// ============================================================
// tb_mul_seq_shift_add: four configurations (8/16 bit, signed/unsigned) against an arithmetic model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mul_seq_shift_add;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [15:0] a_in, b_in;
  logic [3:0]  busy_v, done_v;
  logic [31:0] p16u, p16s;
  logic [15:0] p8u, p8s;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq_shift_add #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .a_i(a_in), .b_i(b_in),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .product_o(p16u));
  mul_seq_shift_add #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .a_i(a_in), .b_i(b_in),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .product_o(p16s));
  mul_seq_shift_add #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .a_i(a_in[7:0]), .b_i(b_in[7:0]),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .product_o(p8u));
  mul_seq_shift_add #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .start_i(start_v[3]), .a_i(a_in[7:0]), .b_i(b_in[7:0]),
    .busy_o(busy_v[3]), .done_o(done_v[3]), .product_o(p8s));

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int get_w(int i);
    return (i < 2) ? 16 : 8;
  endfunction

  function automatic bit get_s(int i);
    return (i % 2) == 1;
  endfunction

  function automatic logic [31:0] get_prod(int i);
    case (i)
      0:       return p16u;
      1:       return p16s;
      2:       return {16'h0, p8u};
      default: return {16'h0, p8s};
    endcase
  endfunction

  // Operand value as the mathematical integer it represents.
  function automatic longint sval(int w, bit sg, logic [15:0] v);
    longint x;
    x = longint'(v) & ((longint'(1) << w) - 1);
    if (sg && x[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic logic [31:0] ref_mul(int w, bit sg, logic [15:0] av, logic [15:0] bv);
    longint p;
    p = sval(w, sg, av) * sval(w, sg, bv);
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_n(int w, bit sg, logic [15:0] bv);
    longint m;
    int     n;
    m = sval(w, sg, bv);
    if (m < 0) m = -m;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  task automatic run_op(input int inst, input logic [15:0] av, input logic [15:0] bv, input bit spam);
    int          w, exp_n, done_at, busy_cnt;
    bit          sg, stable;
    logic [31:0] exp_p, prev_p;
    w       = get_w(inst);
    sg      = get_s(inst);
    exp_p   = ref_mul(w, sg, av, bv);
    exp_n   = ref_n(w, sg, bv);
    done_at = -1;
    busy_cnt = 0;
    stable  = 1'b1;
    @(negedge clk);
    prev_p        = get_prod(inst);
    a_in          = av;
    b_in          = bv;
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    if (!spam) start_v[inst] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_v[inst]) busy_cnt++;
      if (done_v[inst]) begin
        done_at = k;
        break;
      end
      if (get_prod(inst) !== prev_p) stable = 1'b0;
      if (spam) begin
        start_v[inst] = 1'($urandom_range(0, 1));
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end
    end
    check("latency", 32'(done_at), 32'(exp_n));
    check("product", get_prod(inst), exp_p);
    check("stable_while_busy", {31'b0, stable}, 32'd1);
    check("busy_len", 32'(busy_cnt), 32'(exp_n + 1));
    if (spam) start_v[inst] = 1'b1;
    @(negedge clk);
    check("done_pulse", {31'b0, done_v[inst]}, 32'd0);
    check("busy_fall", {31'b0, busy_v[inst]}, 32'd0);
    start_v[inst] = 1'b0;
    if (spam) begin
      @(negedge clk);
      check("no_reload", {31'b0, busy_v[inst]}, 32'd0);
      check("product_held", get_prod(inst), exp_p);
    end
  endtask

  initial begin
    logic [15:0] av, bv;
    rst     = 1'b1;
    start_v = '0;
    a_in    = '0;
    b_in    = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", {31'b0, busy_v[i]}, 32'd0);
      check("rst_done", {31'b0, done_v[i]}, 32'd0);
      check("rst_product", get_prod(i), 32'd0);
    end
    rst = 1'b0;

    run_op(0, 16'd17, 16'd10, 1'b0);
    run_op(1, 16'hFFFD, 16'd7, 1'b0);
    run_op(1, 16'h8000, 16'h8000, 1'b0);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(0, 16'h1234, 16'h0000, 1'b0);
    run_op(3, 16'h0080, 16'h0080, 1'b0);
    run_op(0, 16'd5, 16'd6, 1'b1);
    run_op(0, 16'd3, 16'd3, 1'b0);

    // Asynchronous reset between clock edges during the second iteration.
    @(negedge clk);
    a_in = 16'd200;
    b_in = 16'd255;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy_v[0]}, 32'd0);
    check("arst_done", {31'b0, done_v[0]}, 32'd0);
    check("arst_product", get_prod(0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'd2, 16'd2, 1'b0);

    for (int i = 0; i < 4; i++) begin
      repeat (30) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        case ($urandom_range(0, 7))
          0:       bv = 16'h0000;
          1:       bv = 16'h8080;
          2:       av = 16'h8080;
          3:       bv = bv >> $urandom_range(0, 15);
          default: ;
        endcase
        run_op(i, av, bv, ($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mul_seq_shift_add.md
# mul_seq_shift_add

Parametrised sequential multiplier using shift-and-add with a start/done handshake. It replaces the repeated-addition multiplier: latency now depends on the operand bit length, not the operand value. It adds configurable width, an optional signed mode, early termination and a busy flag. It sits beside the existing datapath/controller arithmetic blocks and is driven by a local sequencer.

## Interface
- WIDTH, 16: operand width in bits (≥2); product is 2*WIDTH bits.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and product.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result register; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE. Encoding is binary, 2 bits.
- IDLE with start=1 (load edge):
  - capture |a| into mcand (2*WIDTH, zero-extended) and |b| into mplr (WIDTH).
  - clear acc.
  - neg = SIGNED & (a[MSB] ^ b[MSB]).
  - if |b| = 0, go to DONE and write product=0; otherwise go to RUN.
- Magnitude in signed mode is the two's-complement absolute value taken as unsigned WIDTH bits. -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
- RUN, each edge:
  - if mplr[0], acc += mcand.
  - mcand <<= 1; mplr >>= 1.
  - if the shifted mplr = 0, write product = neg ? -acc_next : acc_next and go to DONE.
- Iteration count n = (index of highest set bit of |b|) + 1, giving 1..WIDTH. No separate counter is needed because mplr empties after n shifts.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start in RUN or DONE is ignored and not queued. start is re-sampled only once back in IDLE.
- Arithmetic: acc is 2*WIDTH bits and never overflows, since the unsigned magnitude product is < 2^(2*WIDTH). Negation is modulo 2^(2*WIDTH).
- Reset values: state=IDLE, busy=0, done=0, product=0. Internal registers are cleared as well.

## Timing
- Load edge = edge 0.
- Nonzero b: iterations occur on edges 1..n. done and the new product are visible in the cycle after edge n; busy falls after edge n+1.
- b=0: done is visible in the cycle after edge 0.
- Back-to-back: start held high in the DONE cycle is ignored. The earliest next load is edge n+2.
- Reset asserted mid-RUN or in DONE: outputs go to their reset values immediately, with no done pulse. The operation is discarded.
- product changes only on the edge entering DONE and on reset. It is stable while busy.

## Structure
- Shared package mul_pkg holds:
  - the state encodings (IDLE, RUN, DONE) as localparams;
  - the STATE_W constant.
- Sub-module mul_seq_datapath holds mcand, mplr, acc, neg, the magnitude/negate logic and the product register. It exports mplr_zero_next.
- The top-level keeps the FSM (controller), matching the team's existing datapath/controller split.

## Test plan
- WIDTH=16, SIGNED=0, a=17, b=10 -> product=170, done in the cycle after edge 4 (n=4), busy high for 5 cycles.
- SIGNED=1, a=-3 (0xFFFD), b=7 -> product=0xFFFFFFEB (-21), n=3. Also a=-32768, b=-32768 -> 0x40000000, n=16.
- SIGNED=0, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, done after edge 16. Separately, b=0, a=0x1234 -> product=0, done the cycle after the load edge.
- Start pulses during RUN and during DONE while computing 5×6 -> a single result 30, exactly one done pulse. A second operation (3×3=9) completes only after re-sampling in IDLE.
- Assert rst asynchronously mid-edge at iteration 2 of 200×255 -> busy, done and product drop to 0 without waiting for clk. The next start of 2×2 yields 4.
- Random regression, both SIGNED values, WIDTH=8 and 16: check the result against a reference multiply. Check n against the msb index of |b|, and check that done is a one-cycle pulse.
